// File: rtl/mem_pkg.sv
// Shared definitions for the cache fill path: fill FSM state encoding,
// default block geometry and the block-base helper.
package mem_pkg;

  localparam int unsigned BEATS_DEFAULT     = 8;
  localparam int unsigned ADDR_STEP_DEFAULT = 2;
  localparam int unsigned CNT_W             = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IC_XFER = 2'd1,
    DC_XFER = 2'd2
  } fill_state_e;

  // A fill always starts at the 16-byte block boundary of the miss address.
  function automatic logic [15:0] block_base(input logic [15:0] addr);
    return {addr[15:4], 4'h0};
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Small up-counter with enable, synchronous clear and asynchronous reset,
// used to count issued and returned beats of a fill.
module beat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I-cache and D-cache block fills onto a single in-order main
// memory read port; round-robin on ties, one IDLE cycle between transfers.
module mem_fill_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned BEATS     = BEATS_DEFAULT,
  parameter int unsigned ADDR_STEP = ADDR_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ic_req,
  input  logic [15:0] ic_addr,
  input  logic        dc_req,
  input  logic [15:0] dc_addr,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [15:0] rsp_data,
  output logic        ic_valid,
  output logic        dc_valid,
  output logic        ic_grant,
  output logic        dc_grant
);

  fill_state_e      r_state;
  logic             r_last_dc;
  logic [15:0]      r_base;

  logic             w_xfer;
  logic             w_issue;
  logic             w_rtn;
  logic             w_last_rtn;
  logic             w_any_req;
  logic             w_pick_dc;
  logic [CNT_W-1:0] w_issue_cnt;
  logic [CNT_W-1:0] w_rtn_cnt;

  assign w_xfer     = (r_state != IDLE);
  assign w_issue    = w_xfer && (32'(w_issue_cnt) < BEATS);
  assign w_rtn      = w_xfer && mem_rvalid;
  assign w_last_rtn = w_rtn && (32'(w_rtn_cnt) == BEATS - 1);

  // On a tie the cache that was not granted last wins.
  assign w_any_req  = ic_req || dc_req;
  assign w_pick_dc  = dc_req && (!ic_req || !r_last_dc);

  beat_counter #(.W(CNT_W)) u_issue_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_issue),
    .i_clr   (w_last_rtn),
    .o_count (w_issue_cnt)
  );

  beat_counter #(.W(CNT_W)) u_rtn_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_rtn),
    .i_clr   (w_last_rtn),
    .o_count (w_rtn_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last_dc <= 1'b0;
      r_base    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state   <= w_pick_dc ? DC_XFER : IC_XFER;
            r_last_dc <= w_pick_dc;
            r_base    <= block_base(w_pick_dc ? dc_addr : ic_addr);
          end
        end
        IC_XFER, DC_XFER: begin
          // Requests are not looked at here: reads already issued cannot be cancelled.
          if (w_last_rtn) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ic_grant = (r_state == IC_XFER);
  assign dc_grant = (r_state == DC_XFER);

  assign mem_en   = w_issue;
  assign mem_addr = w_issue ? (r_base + 16'(ADDR_STEP * 32'(w_issue_cnt))) : '0;

  assign rsp_data = mem_rdata;
  assign ic_valid = mem_rvalid && (r_state == IC_XFER);
  assign dc_valid = mem_rvalid && (r_state == DC_XFER);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a fixed-latency (4 cycle) memory
// model returning addr ^ 16'h5A5A as read data.
module tb_mem_fill_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ic_req;
  logic [15:0] ic_addr;
  logic        dc_req;
  logic [15:0] dc_addr;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [15:0] rsp_data;
  logic        ic_valid;
  logic        dc_valid;
  logic        ic_grant;
  logic        dc_grant;

  int n_checks = 0;
  int n_fail   = 0;

  logic        pv [4];
  logic [15:0] pa [4];
  logic        inj;
  logic        s_en;
  logic [15:0] s_addr;

  mem_fill_arbiter #(.BEATS(8), .ADDR_STEP(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ic_req     (ic_req),
    .ic_addr    (ic_addr),
    .dc_req     (dc_req),
    .dc_addr    (dc_addr),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .rsp_data   (rsp_data),
    .ic_valid   (ic_valid),
    .dc_valid   (dc_valid),
    .ic_grant   (ic_grant),
    .dc_grant   (dc_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rvalid = pv[3] | inj;
  assign mem_rdata  = pv[3] ? (pa[3] ^ 16'h5A5A) : 16'h0000;

  // Memory: read issued in cycle t returns in cycle t+4, in order.
  initial begin
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pa[i] = 16'h0000;
    end
    forever begin
      @(negedge clk);
      #3;
      s_en   = mem_en;
      s_addr = mem_addr;
      @(posedge clk);
      #1;
      for (int i = 3; i > 0; i--) begin
        pv[i] = pv[i-1];
        pa[i] = pa[i-1];
      end
      pv[0] = s_en;
      pa[0] = s_addr;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_icg"},  32'(ic_grant), 32'd0);
    check({tag, "_dcg"},  32'(dc_grant), 32'd0);
    check({tag, "_en"},   32'(mem_en),   32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_icv"},  32'(ic_valid), 32'd0);
    check({tag, "_dcv"},  32'(dc_valid), 32'd0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n  = 1'b0;
    ic_req = 1'b0;
    dc_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Follows one transfer from the first granted cycle until the return to IDLE.
  task automatic run_xfer(input bit is_ic, input logic [15:0] base, input int drop_after,
                          input string tag);
    int          issued;
    int          returned;
    int          other;
    bit          done;
    logic        own_g;
    logic        own_v;
    logic        oth_v;
    logic [15:0] exp_a;
    issued   = 0;
    returned = 0;
    other    = 0;
    done     = 1'b0;
    @(negedge clk);
    check({tag, "_grant"},   32'(is_ic ? ic_grant : dc_grant), 32'd1);
    check({tag, "_nogrant"}, 32'(is_ic ? dc_grant : ic_grant), 32'd0);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      own_g = is_ic ? ic_grant : dc_grant;
      own_v = is_ic ? ic_valid : dc_valid;
      oth_v = is_ic ? dc_valid : ic_valid;
      if (!own_g) begin
        done = 1'b1;
      end else begin
        if (oth_v) other++;
        if (is_ic ? dc_grant : ic_grant) other++;
        if (mem_en) begin
          exp_a = base + 16'(issued * 2);
          check({tag, "_addr"},   32'(mem_addr), 32'(exp_a));
          check({tag, "_consec"}, 32'(cyc), 32'(issued));
          issued++;
          if (issued == drop_after) begin
            if (is_ic) ic_req = 1'b0;
            else       dc_req = 1'b0;
          end
          if (issued == 3) begin
            if (is_ic) ic_addr = 16'hBEEF;
            else       dc_addr = 16'hBEEF;
          end
        end else begin
          check({tag, "_addr_off"}, 32'(mem_addr), 32'd0);
        end
        if (own_v) begin
          exp_a = base + 16'(returned * 2);
          check({tag, "_data"}, 32'(rsp_data), 32'(exp_a ^ 16'h5A5A));
          returned++;
        end
      end
    end
    check({tag, "_done"},     32'(done), 32'd1);
    check({tag, "_issued"},   32'(issued), 32'd8);
    check({tag, "_returned"}, 32'(returned), 32'd8);
    check({tag, "_other"},    32'(other), 32'd0);
    check({tag, "_idle_en"},  32'(mem_en), 32'd0);
  endtask

  initial begin
    int n;
    rst_n   = 1'b1;
    ic_req  = 1'b0;
    dc_req  = 1'b0;
    ic_addr = 16'h0000;
    dc_addr = 16'h0000;
    inj     = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests straight out of reset: D-cache first, then I-cache.
    ic_addr = 16'h3456;
    dc_addr = 16'h789A;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    run_xfer(1'b0, 16'h7890, 1, "tie_dc");
    run_xfer(1'b1, 16'h3450, 1, "tie_ic");

    do_reset();
    ic_addr = 16'h1236;
    ic_req  = 1'b1;
    run_xfer(1'b1, 16'h1230, 8, "ic_basic");

    dc_addr = 16'hFFF4;
    dc_req  = 1'b1;
    run_xfer(1'b0, 16'hFFF0, 8, "dc_top");

    dc_addr = 16'h4A5C;
    dc_req  = 1'b1;
    run_xfer(1'b0, 16'h4A50, 2, "dc_drop");

    // Reset asserted while the fifth beat is being issued.
    ic_addr = 16'h2004;
    ic_req  = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      @(negedge clk);
      if (mem_en) n++;
    end
    check("midrst_reach", 32'(n), 32'd5);
    rst_n  = 1'b0;
    ic_req = 1'b0;
    #1;
    check_quiet("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("stale_icv", 32'(ic_valid), 32'd0);
      check("stale_dcv", 32'(dc_valid), 32'd0);
      check("stale_en",  32'(mem_en),   32'd0);
    end

    // Stray read-valid pulses while idle must not disturb the next fill.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      inj = 1'b1;
      #1;
      check("idle_icv", 32'(ic_valid), 32'd0);
      check("idle_dcv", 32'(dc_valid), 32'd0);
    end
    @(negedge clk);
    inj     = 1'b0;
    ic_addr = 16'h0A0F;
    ic_req  = 1'b1;
    run_xfer(1'b1, 16'h0A00, 1, "post_idle");

    repeat (6) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
